// File: rtl/iter_shifter_if.sv
// Request/result bus for iter_shifter: operand request in, shifted result out.
// Valid/ready semantics for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the sender holds valid and payload
// stable until that edge, and ready may not depend combinationally on valid.
interface iter_shifter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        out_err;

  modport master (
    output in_valid, data_in, shamt, op, out_ready,
    input  in_ready, out_valid, data_out, out_err
  );

  modport slave (
    input  in_valid, data_in, shamt, op, out_ready,
    output in_ready, out_valid, data_out, out_err
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle 32-bit shifter: one fixed stage (16,8,4,2,1) per cycle, SLL/SRA,
// plus SRL when SHIFT_SRL_EN is defined (otherwise op=10 is reported as reserved).
module iter_shifter (
  input  logic              clock,
  input  logic              reset_n,
  iter_shifter_if.slave     bus,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  lat_shamt;
  logic [1:0]  lat_op;
  logic        err;
  logic [2:0]  k;

  logic [31:0] sll_stage;
  logic [31:0] sra_stage;
  logic [31:0] stage_out;
  logic [31:0] next_acc;
  logic        op_rsvd;
  logic        step_en;

  assign dbg_state = state;

  // Fixed-distance shifters; k selects which constant stage feeds the mux.
  always_comb begin
    sll_stage = acc;
    sra_stage = acc;
    case (k)
      3'd0: begin sll_stage = acc << 16; sra_stage = $unsigned($signed(acc) >>> 16); end
      3'd1: begin sll_stage = acc << 8;  sra_stage = $unsigned($signed(acc) >>> 8);  end
      3'd2: begin sll_stage = acc << 4;  sra_stage = $unsigned($signed(acc) >>> 4);  end
      3'd3: begin sll_stage = acc << 2;  sra_stage = $unsigned($signed(acc) >>> 2);  end
      3'd4: begin sll_stage = acc << 1;  sra_stage = $unsigned($signed(acc) >>> 1);  end
      default: ;
    endcase
  end

`ifdef SHIFT_SRL_EN
  logic [31:0] srl_stage;

  always_comb begin
    srl_stage = acc;
    case (k)
      3'd0: srl_stage = acc >> 16;
      3'd1: srl_stage = acc >> 8;
      3'd2: srl_stage = acc >> 4;
      3'd3: srl_stage = acc >> 2;
      3'd4: srl_stage = acc >> 1;
      default: ;
    endcase
  end

  assign op_rsvd = (bus.op == 2'b11);
`else
  assign op_rsvd = bus.op[1];
`endif

  always_comb begin
    stage_out = acc;
    case (lat_op)
      2'b00: stage_out = sll_stage;
      2'b01: stage_out = sra_stage;
`ifdef SHIFT_SRL_EN
      2'b10: stage_out = srl_stage;
`endif
      default: stage_out = acc;
    endcase
  end

  // Stage k handles distance 16>>k, i.e. shamt bit 4-k; errored requests pass through.
  assign step_en  = lat_shamt[3'd4 - k] && !err;
  assign next_acc = step_en ? stage_out : acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      acc           <= '0;
      lat_shamt     <= '0;
      lat_op        <= '0;
      err           <= 1'b0;
      k             <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.out_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            acc          <= bus.data_in;
            lat_shamt    <= bus.shamt;
            lat_op       <= bus.op;
            err          <= op_rsvd;
            k            <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= next_acc;
          if (k == 3'd4) begin
            bus.out_valid <= 1'b1;
            bus.data_out  <= next_acc;
            bus.out_err   <= err;
            state         <= DONE;
          end else begin
            k <= k + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.out_err   <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: hand-computed vectors checked with immediate
// assertions; expectations for op=10 follow the SHIFT_SRL_EN build.
module tb_iter_shifter;

  logic       clock;
  logic       reset_n;
  logic       busy;
  logic [1:0] dbg_state;
  int         vectors;
  int         miscompares;

  iter_shifter_if bus ();

  iter_shifter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full request with out_ready high: accept on N, result after N+5, handshake on N+6.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input logic [31:0] exp_d, input logic exp_e);
    chk({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.data_in   = d;
    bus.shamt     = s;
    bus.op        = o;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.data_in  = ~d;
    bus.shamt    = ~s;
    bus.op       = ~o;
    chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    chk({tag, " in_ready_after_accept"}, 32'(bus.in_ready), 32'd0);
    repeat (4) tick();
    chk({tag, " out_valid_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, " out_valid_n5"}, 32'(bus.out_valid), 32'd1);
    chk({tag, " data_out"}, bus.data_out, exp_d);
    chk({tag, " out_err"}, 32'(bus.out_err), 32'(exp_e));
    chk({tag, " in_ready_done"}, 32'(bus.in_ready), 32'd0);
    chk({tag, " state_done"}, 32'(dbg_state), 32'd2);
    tick();
    chk({tag, " out_valid_after_hs"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready_after_hs"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " out_err_after_hs"}, 32'(bus.out_err), 32'd0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.shamt     = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_err", 32'(bus.out_err), 32'd0);
    chk("rst data_out", bus.data_out, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("post_rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst state", 32'(dbg_state), 32'd0);

    // main function
    run_op("sra16", 32'h8000_0000, 5'd16, 2'b01, 32'hFFFF_8000, 1'b0);
    run_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
    run_op("sll0", 32'h0000_0001, 5'd0, 2'b00, 32'h0000_0001, 1'b0);
    run_op("sll12", 32'h0000_ABCD, 5'd12, 2'b00, 32'h0ABC_D000, 1'b0);
    run_op("sra31", 32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF, 1'b0);
    run_op("sra4_pos", 32'h1234_5678, 5'd4, 2'b01, 32'h0123_4567, 1'b0);
    run_op("sra0", 32'hDEAD_BEEF, 5'd0, 2'b01, 32'hDEAD_BEEF, 1'b0);
    run_op("op11", 32'h1234_5678, 5'd5, 2'b11, 32'h1234_5678, 1'b1);
`ifdef SHIFT_SRL_EN
    run_op("srl4", 32'h8000_0000, 5'd4, 2'b10, 32'h0800_0000, 1'b0);
    run_op("srl31", 32'hFFFF_FFFF, 5'd31, 2'b10, 32'h0000_0001, 1'b0);
`else
    run_op("srl4_rsvd", 32'h8000_0000, 5'd4, 2'b10, 32'h8000_0000, 1'b1);
    run_op("srl31_rsvd", 32'hFFFF_FFFF, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b1);
`endif

    // backpressure: result held for 10 cycles with out_ready low
    chk("bp in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.data_in   = 32'h7000_000F;
    bus.shamt     = 5'd3;
    bus.op        = 2'b01;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid_held", 32'(bus.out_valid), 32'd1);
      chk("bp data_out_held", bus.data_out, 32'h0E00_0001);
      chk("bp in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    chk("bp in_ready_after_hs", 32'(bus.in_ready), 32'd1);

    // inputs change during SHIFT; second request waits for IDLE
    bus.data_in  = 32'hF000_0000;
    bus.shamt    = 5'd8;
    bus.op       = 2'b01;
    bus.in_valid = 1'b1;
    tick();
    bus.data_in = 32'h0;
    bus.shamt   = 5'd0;
    for (int i = 0; i < 4; i++) begin
      chk("mid in_ready_shift", 32'(bus.in_ready), 32'd0);
      tick();
    end
    tick();
    chk("mid out_valid", 32'(bus.out_valid), 32'd1);
    chk("mid data_out", bus.data_out, 32'hFFF0_0000);
    chk("mid in_ready_done", 32'(bus.in_ready), 32'd0);
    tick();
    chk("mid in_ready_idle", 32'(bus.in_ready), 32'd1);
    chk("mid busy_idle", 32'(busy), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("mid second_accepted", 32'(busy), 32'd1);
    repeat (5) tick();
    chk("mid second_valid", 32'(bus.out_valid), 32'd1);
    chk("mid second_data", bus.data_out, 32'h0);
    tick();
    chk("mid second_hs", 32'(bus.in_ready), 32'd1);

    // reset during SHIFT at k=2, after a nonzero data_out from a prior op
    run_op("pre_rst", 32'h0000_00FF, 5'd8, 2'b00, 32'h0000_FF00, 1'b0);
    bus.data_in  = 32'h0000_0001;
    bus.shamt    = 5'd1;
    bus.op       = 2'b00;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort data_out", bus.data_out, 32'h0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort state", 32'(dbg_state), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    run_op("after_rst", 32'h0000_0003, 5'd2, 2'b00, 32'h0000_000C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
